// File: rtl/glip_uart_rx_frontend_if.sv
// Byte stream handshake between the UART receive front end and its consumer.
// The master drives data/valid, the slave drives ready.
interface glip_uart_rx_frontend_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/glip_uart_rx_frontend.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote, false-start
// rejection, framing/break detection and a small FWFT output buffer.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge
//   START     | validating the start bit at mid-bit
//   DATA      | sampling 8 data bits, LSB first
//   STOP      | checking the stop bit; push or flag a framing error
//   WAIT_IDLE | bad stop bit seen, waiting for the line to return high
module glip_uart_rx_frontend #(
  parameter int DIVISOR   = 217,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx,
  glip_uart_rx_frontend_if.master        stream,
  output logic                           frame_error,
  output logic                           overrun,
  output logic                           break_detect
);

  localparam int CW   = $clog2(DIVISOR);
  localparam int H    = DIVISOR / 2;
  localparam int AW   = $clog2(BUF_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   C_S0    = CW'(H - 1);
  localparam logic [CW-1:0]   C_S1    = CW'(H);
  localparam logic [CW-1:0]   C_DEC   = CW'(H + 1);
  localparam logic [CW-1:0]   C_END   = CW'(DIVISOR - 1);
  localparam logic [CNTW-1:0] C_DEPTH = CNTW'(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t state, state_next;

  logic          sync_a, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          samp_a, samp_b;

  logic fall, maj;
  logic at_s0, at_s1, at_dec, at_end;
  logic cnt_clr, store_bit, idx_inc, idx_clr;
  logic push, ferr, brk_set, brk_clr;

  logic [7:0]      mem [BUF_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CNTW-1:0] count;
  logic            pop, push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_a  <= rx;
      rx_s    <= sync_a;
      rx_prev <= rx_s;
    end
  end

  assign fall   = !rx_s && rx_prev;
  assign at_s0  = (cnt == C_S0);
  assign at_s1  = (cnt == C_S1);
  assign at_dec = (cnt == C_DEC);
  assign at_end = (cnt == C_END);
  // The third sample is the live synchronized value at the decision count.
  assign maj    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    store_bit  = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    push       = 1'b0;
    ferr       = 1'b0;
    brk_set    = 1'b0;
    brk_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (at_dec && maj) begin
          state_next = IDLE;
        end else if (at_end) begin
          state_next = DATA;
          cnt_clr    = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      DATA: begin
        if (at_dec) store_bit = 1'b1;
        if (at_end) begin
          cnt_clr = 1'b1;
          if (idx == 3'd7) state_next = STOP;
          else             idx_inc    = 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (at_dec) begin
          if (maj) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr       = 1'b1;
            brk_set    = (shift == 8'h00);
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          brk_clr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else begin
      if (cnt_clr || state_next == IDLE || state_next == WAIT_IDLE) cnt <= '0;
      else                                                          cnt <= cnt + 1'b1;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (store_bit) shift[idx] <= maj;
      if (at_s0) samp_a <= rx_s;
      if (at_s1) samp_b <= rx_s;
    end
  end

  assign pop     = (count != '0) && stream.out_ready;
  assign push_ok = push && ((count != C_DEPTH) || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign stream.out_valid = (count != '0);
  assign stream.out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      frame_error <= ferr;
      overrun     <= push && !push_ok;
      if (brk_set)      break_detect <= 1'b1;
      else if (brk_clr) break_detect <= 1'b0;
    end
  end

endmodule
